// File: rtl/alu_issue_ctrl.sv
// Issue controller between a host request port and a pipelined ALU stage.
// Optional ALU_ISSUE_PERF_EN adds saturating handshake/stall counters.
package alu_pkg;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned RES_W  = 18;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned CNT_W  = 16;

    typedef struct packed {
        logic             pre_x_en;
        logic             pre_x_sub;
        logic             pre_y_en;
        logic             pre_y_sub;
        logic [SEL_W-1:0] mul_x_sel;
        logic [SEL_W-1:0] mul_y_sel;
        logic             mul_en;
        logic             post_en;
        logic             post_sub;
    } alu_ctrl_t;
endpackage

module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_x0,
    input  logic [DATA_W-1:0] in_x1,
    input  logic [DATA_W-1:0] in_y0,
    input  logic [DATA_W-1:0] in_y1,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [DATA_W-1:0] x0,
    output logic [DATA_W-1:0] x1,
    output logic [DATA_W-1:0] y0,
    output logic [DATA_W-1:0] y1,
    output alu_ctrl_t         ctrl,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [RES_W-1:0]  res_q,
    input  logic              carry_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_res,
    output logic              out_carry,
    output logic              out_err
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_ops,
    output logic [CNT_W-1:0]  perf_stall
`endif
);

    localparam logic [OP_W-1:0] OP_ERR = OP_W'(7);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              res_ready_q, res_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    alu_ctrl_t         ctrl_q, ctrl_d;
    logic [RES_W-1:0]  out_res_q, out_res_d;
    logic              out_carry_q, out_carry_d;
    logic              out_err_q, out_err_d;

    // Opcode to ALU datapath control; sel 5 feeds zero, opcode 7 decodes to all-zero.
    function automatic alu_ctrl_t decode_op(input logic [OP_W-1:0] op);
        alu_ctrl_t c;
        c = '0;
        case (op)
            3'd0: begin
                c.mul_x_sel = SEL_W'(3);
                c.mul_y_sel = SEL_W'(5);
            end
            3'd1, 3'd2: begin
                c.pre_x_en  = 1'b1;
                c.pre_y_en  = 1'b1;
                c.mul_x_sel = SEL_W'(4);
                c.mul_y_sel = SEL_W'(4);
                c.post_sub  = (op == 3'd2);
            end
            3'd3, 3'd6: begin
                c.mul_x_sel = SEL_W'(3);
                c.mul_y_sel = SEL_W'(3);
                c.post_sub  = (op == 3'd6);
            end
            3'd4: begin
                c.pre_x_en  = 1'b1;
                c.pre_x_sub = 1'b1;
                c.mul_x_sel = SEL_W'(2);
                c.mul_y_sel = SEL_W'(5);
            end
            3'd5: begin
                c.pre_x_en  = 1'b1;
                c.pre_y_en  = 1'b1;
                c.mul_x_sel = SEL_W'(2);
                c.mul_y_sel = SEL_W'(2);
            end
            default: ;
        endcase
        if (op != OP_ERR) begin
            c.mul_en  = 1'b1;
            c.post_en = 1'b1;
        end
        return c;
    endfunction

    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        y0_d        = y0_q;
        y1_d        = y1_q;
        ctrl_d      = ctrl_q;
        out_res_d   = out_res_q;
        out_carry_d = out_carry_q;
        out_err_d   = out_err_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x0_d   = in_x0;
                    x1_d   = in_x1;
                    y0_d   = in_y0;
                    y1_d   = in_y1;
                    ctrl_d = decode_op(in_op);
                    if (in_op == OP_ERR) begin
                        out_res_d   = '0;
                        out_carry_d = 1'b0;
                        out_err_d   = 1'b1;
                        state_d     = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (res_valid) begin
                    out_res_d   = res_q;
                    out_carry_d = carry_q;
                    out_err_d   = 1'b0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags are registered copies of the next-state decode.
        in_ready_d  = (state_d == IDLE);
        cmd_valid_d = (state_d == ISSUE);
        res_ready_d = (state_d == WAIT);
        out_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            cmd_valid_q <= 1'b0;
            res_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            x0_q        <= '0;
            x1_q        <= '0;
            y0_q        <= '0;
            y1_q        <= '0;
            ctrl_q      <= '0;
            out_res_q   <= '0;
            out_carry_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            cmd_valid_q <= cmd_valid_d;
            res_ready_q <= res_ready_d;
            out_valid_q <= out_valid_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            y0_q        <= y0_d;
            y1_q        <= y1_d;
            ctrl_q      <= ctrl_d;
            out_res_q   <= out_res_d;
            out_carry_q <= out_carry_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign cmd_valid = cmd_valid_q;
    assign res_ready = res_ready_q;
    assign out_valid = out_valid_q;
    assign x0        = x0_q;
    assign x1        = x1_q;
    assign y0        = y0_q;
    assign y1        = y1_q;
    assign ctrl      = ctrl_q;
    assign out_res   = out_res_q;
    assign out_carry = out_carry_q;
    assign out_err   = out_err_q;

`ifdef ALU_ISSUE_PERF_EN
    logic [CNT_W-1:0] perf_ops_q, perf_ops_d;
    logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
    logic             ops_inc, stall_inc;

    // Saturating counters: completed responses and back-pressured cycles.
    always_comb begin
        ops_inc      = (state_q == RESP) && out_ready;
        stall_inc    = ((state_q == ISSUE) && !cmd_ready) || ((state_q == RESP) && !out_ready);
        perf_ops_d   = perf_ops_q;
        perf_stall_d = perf_stall_q;
        if (ops_inc && (perf_ops_q != '1)) begin
            perf_ops_d = perf_ops_q + CNT_W'(1);
        end
        if (stall_inc && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl; a small ALU model answers commands from x0..y1/ctrl.
// Counter checks are included when ALU_ISSUE_PERF_EN is defined.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [7:0]  in_x0, in_x1, in_y0, in_y1;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  x0, x1, y0, y1;
    alu_ctrl_t   ctrl;
    logic        res_valid;
    logic        res_ready;
    logic [17:0] alu_res;
    logic        alu_carry;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_res;
    logic        out_carry;
    logic        out_err;
`ifdef ALU_ISSUE_PERF_EN
    logic [15:0] perf_ops, perf_stall;
`endif

    int tests = 0;
    int fails = 0;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_x0(in_x0), .in_x1(in_x1), .in_y0(in_y0), .in_y1(in_y1),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .ctrl(ctrl),
        .res_valid(res_valid), .res_ready(res_ready), .res_q(alu_res), .carry_q(alu_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_carry(out_carry), .out_err(out_err)
`ifdef ALU_ISSUE_PERF_EN
        , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural ALU: sel 2 squares the pre-stage sum/diff, 3 takes the cross product,
    // 4 passes the pre-stage value, 5 contributes zero.
    function automatic logic [18:0] alu_model(input alu_ctrl_t c, input logic [7:0] a0, a1, b0, b1);
        logic [8:0]  px, py;
        logic [17:0] tx, ty;
        px = c.pre_x_sub ? 9'(a0) - 9'(a1) : 9'(a0) + 9'(a1);
        py = c.pre_y_sub ? 9'(b0) - 9'(b1) : 9'(b0) + 9'(b1);
        case (c.mul_x_sel)
            3'd2:    tx = 18'(px) * 18'(px);
            3'd3:    tx = 18'(a0) * 18'(b1);
            3'd4:    tx = 18'(px);
            default: tx = '0;
        endcase
        case (c.mul_y_sel)
            3'd2:    ty = 18'(py) * 18'(py);
            3'd3:    ty = 18'(b0) * 18'(a1);
            3'd4:    ty = 18'(py);
            default: ty = '0;
        endcase
        return c.post_sub ? 19'(tx) - 19'(ty) : 19'(tx) + 19'(ty);
    endfunction

    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a0, a1, b0, b1,
                          input int cmd_stall, input int out_stall,
                          input logic [2:0] exp_xsel, input logic [2:0] exp_ysel, input logic exp_sub,
                          input logic [17:0] exp_res, input logic exp_carry);
        logic [31:0] snap_ops, snap_ctrl;
        logic [18:0] r;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_op = op; in_x0 = a0; in_x1 = a1; in_y0 = b0; in_y1 = b1;
        step();
        in_valid = 1'b0; in_x0 = 8'hA5; in_x1 = 8'h5A; in_y0 = 8'hC3; in_y1 = 8'h3C;
        chk({tag, ".cmd_valid"}, 32'(cmd_valid), 32'd1);
        chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        chk({tag, ".mul_x_sel"}, 32'(ctrl.mul_x_sel), 32'(exp_xsel));
        chk({tag, ".mul_y_sel"}, 32'(ctrl.mul_y_sel), 32'(exp_ysel));
        chk({tag, ".post_sub"}, 32'(ctrl.post_sub), 32'(exp_sub));
        snap_ops  = {x0, x1, y0, y1};
        snap_ctrl = 32'(ctrl);
        cmd_ready = 1'b0;
        for (int i = 0; i < cmd_stall; i++) begin
            res_valid = 1'b1; alu_res = 18'h1234; alu_carry = 1'b1;
            step();
            chk({tag, ".stall_valid"}, 32'(cmd_valid), 32'd1);
            chk({tag, ".stall_ops"}, {x0, x1, y0, y1}, snap_ops);
            chk({tag, ".stall_ctrl"}, 32'(ctrl), snap_ctrl);
        end
        res_valid = 1'b0;
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        chk({tag, ".res_ready"}, 32'(res_ready), 32'd1);
        chk({tag, ".cmd_done"}, 32'(cmd_valid), 32'd0);
        r = alu_model(ctrl, x0, x1, y0, y1);
        res_valid = 1'b1; alu_res = r[17:0]; alu_carry = r[18];
        step();
        res_valid = 1'b0; alu_res = '0; alu_carry = 1'b0;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".out_res"}, 32'(out_res), 32'(exp_res));
        chk({tag, ".out_carry"}, 32'(out_carry), 32'(exp_carry));
        chk({tag, ".out_err"}, 32'(out_err), 32'd0);
        out_ready = 1'b0;
        for (int i = 0; i < out_stall; i++) begin
            step();
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_res"}, 32'(out_res), 32'(exp_res));
            chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ".out_done"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0;
        in_x0 = '0; in_x1 = '0; in_y0 = '0; in_y1 = '0;
        cmd_ready = 1'b0; res_valid = 1'b0; alu_res = '0; alu_carry = 1'b0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst.res_ready", 32'(res_ready), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out", {13'd0, out_err, out_carry, out_res}, 32'd0);
        chk("rst.ops", {x0, x1, y0, y1}, 32'd0);
        chk("rst.ctrl", 32'(ctrl), 32'd0);

        // Stray results while idle must not be taken.
        res_valid = 1'b1; alu_res = 18'h2AAAA;
        step();
        res_valid = 1'b0;
        chk("idle_res.out_valid", 32'(out_valid), 32'd0);
        chk("idle_res.res_ready", 32'(res_ready), 32'd0);

        run_op("dot",   3'd3, 8'd3, 8'd4, 8'd5, 8'd6, 0, 0, 3'd3, 3'd3, 1'b0, 18'd38, 1'b0);
        run_op("sub2",  3'd2, 8'd1, 8'd1, 8'd2, 8'd2, 0, 0, 3'd4, 3'd4, 1'b1, 18'h3FFFE, 1'b1);

        in_valid = 1'b1; in_op = 3'd7; in_x0 = 8'd9; in_x1 = 8'd8; in_y0 = 8'd7; in_y1 = 8'd6;
        step();
        in_valid = 1'b0;
        chk("op7.cmd_valid", 32'(cmd_valid), 32'd0);
        chk("op7.out_valid", 32'(out_valid), 32'd1);
        chk("op7.out_err", 32'(out_err), 32'd1);
        chk("op7.out_res", 32'(out_res), 32'd0);
        chk("op7.out_carry", 32'(out_carry), 32'd0);
        chk("op7.ctrl", 32'(ctrl), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("op7.done", 32'(out_valid), 32'd0);
        chk("op7.in_ready", 32'(in_ready), 32'd1);

        run_op("mul",   3'd0, 8'd255, 8'd17, 8'd99, 8'd255, 5, 0, 3'd3, 3'd5, 1'b0, 18'd65025, 1'b0);
`ifdef ALU_ISSUE_PERF_EN
        chk("perf.stall_mul", 32'(perf_stall), 32'd5);
        chk("perf.ops_mul", 32'(perf_ops), 32'd4);
`endif
        run_op("sumsq", 3'd5, 8'd255, 8'd255, 8'd255, 8'd255, 0, 3, 3'd2, 3'd2, 1'b0, 18'h3F008, 1'b1);
        run_op("add2",  3'd1, 8'd10, 8'd20, 8'd30, 8'd40, 1, 1, 3'd4, 3'd4, 1'b0, 18'd100, 1'b0);
        run_op("sqdiff", 3'd4, 8'd1, 8'd3, 8'd200, 8'd100, 0, 0, 3'd2, 3'd5, 1'b0, 18'h3F804, 1'b0);
        run_op("dprod", 3'd6, 8'd2, 8'd5, 8'd4, 8'd3, 0, 0, 3'd3, 3'd3, 1'b1, 18'h3FFF2, 1'b1);

        // Reset while waiting on the ALU abandons the transaction.
        in_valid = 1'b1; in_op = 3'd3; in_x0 = 8'd7; in_x1 = 8'd1; in_y0 = 8'd2; in_y1 = 8'd3;
        step();
        in_valid = 1'b0;
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        chk("rstwait.in_wait", 32'(res_ready), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstwait.in_ready", 32'(in_ready), 32'd1);
        chk("rstwait.flags", {28'd0, cmd_valid, res_ready, out_valid, out_err}, 32'd0);
        chk("rstwait.out", {13'd0, out_err, out_carry, out_res}, 32'd0);
        chk("rstwait.ops", {x0, x1, y0, y1}, 32'd0);
        chk("rstwait.ctrl", 32'(ctrl), 32'd0);
        res_valid = 1'b1; alu_res = 18'd20;
        step();
        res_valid = 1'b0;
        chk("rstwait.no_out", 32'(out_valid), 32'd0);
`ifdef ALU_ISSUE_PERF_EN
        chk("perf.cleared", {perf_ops, perf_stall}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
